// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver (1 start, DATA_BITS data LSB-first, 1 stop).
// Mid-bit sampling off a two-flop synchronizer; completed bytes leave on a valid/ready handshake.
module uart_rx #(
    parameter int unsigned DIVISOR   = 434,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);
    localparam int unsigned TW = $clog2(DIVISOR);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    // Counters restart at 0 on each state entry, so the terminal counts are one below the spans.
    localparam logic [TW-1:0] HALF_LAST = TW'(DIVISOR / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(DIVISOR - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 rxs;
    logic                 complete;

    assign rxs = sync2_q;

    always_comb begin
        sync1_d  = rx_in;
        sync2_d  = sync1_q;
        state_d  = state_q;
        tick_d   = tick_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        complete = 1'b0;

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                if (!rxs) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick_q == HALF_LAST) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_q == BIT_LAST) begin
                    tick_d                 = '0;
                    shift_d                = shift_q >> 1;
                    shift_d[DATA_BITS-1]   = rxs;
                    if (bit_q == DATA_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick_q == BIT_LAST) begin
                    tick_d = '0;
                    if (rxs) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                tick_d = '0;
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tick_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        // A same-cycle accept frees the holding register, so only an unaccepted byte overruns.
        if (complete) begin
            if (valid_q && !data_ready) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data          = data_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
